h14tx_timings_sequencer: RTL and testbench
==========================================

# h14tx_timings_sequencer

Run/stop controller and mode scheduler for the HDMI transmitter's raster timing path. It owns the pixel/line cursor and the active timing mode. It accepts new mode parameters through a valid/ready port and applies them only at a frame boundary. It decodes de/hsync/vsync for the TMDS encoder stage. It sits between the register/config domain logic and the encoder/data-island scheduler.

## Interface
- BitWidth, 11, width of x and all horizontal timing fields
- BitHeight, 10, width of y and all vertical timing fields
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  level; 1 = run raster, 0 = stop at the end of the current frame
- cfg_valid  in  1  mode-write request
- cfg_ready  out  1  shadow slot empty; a write is accepted on cfg_valid && cfg_ready
- cfg_h_total, cfg_h_active, cfg_h_sync_start, cfg_h_sync_end  in  BitWidth each  horizontal mode fields
- cfg_v_total, cfg_v_active, cfg_v_sync_start, cfg_v_sync_end  in  BitHeight each  vertical mode fields
- cfg_sync_pol  in  1  1 = syncs active-high, 0 = syncs active-low
- cfg_error  out  1  one-cycle pulse: last accepted write was invalid and was discarded
- running  out  1  state != STOPPED
- x  out  BitWidth  current pixel column
- y  out  BitHeight  current line
- de  out  1  x < h_active && y < v_active
- hsync, vsync  out  1  sync outputs, already polarity-applied
- frame_start  out  1  pulse while x==0, y==0 and running
- line_start  out  1  pulse while x==0 and running
- frame_count  out  16  frames completed (only with H14TX_TIMINGS_FRAME_COUNT_EN)

## Operation
- States: STOPPED, RUN, DRAIN.
  - STOPPED -> RUN when enable=1.
  - RUN -> DRAIN when enable=0.
  - DRAIN -> RUN if enable returns to 1 before the frame ends.
  - DRAIN -> STOPPED at the last pixel (x==h_total-1 && y==v_total-1).
- Cursor in RUN/DRAIN:
  - x increments by 1 and wraps to 0 at h_total-1.
  - y increments on x wrap and wraps to 0 at v_total-1.
  - In STOPPED, x=y=0 and the cursor is held.
- Active mode registers reset to 720p60: h_total 1650, h_active 1280, h_sync_start 1390, h_sync_end 1430, v_total 750, v_active 720, v_sync_start 725, v_sync_end 730, sync_pol 1.
- Config write:
  - An accepted write is validated first.
  - Valid requires: h_active < h_sync_start < h_sync_end <= h_total, the same ordering on the vertical fields, h_total >= 2, v_total >= 2.
  - Invalid write: discarded; cfg_error pulses on the cycle after acceptance; the shadow slot stays empty.
  - Valid write: stored in the shadow slot; cfg_ready goes to 0.
- Shadow apply:
  - In STOPPED, the shadow copies to the active mode one cycle after the write.
  - In RUN/DRAIN, it copies on the last-pixel cycle, so the next frame's x=0,y=0 already uses the new mode.
  - After the copy, cfg_ready returns to 1.
- Decode:
  - hsync is asserted for x in [h_sync_start, h_sync_end).
  - vsync is asserted for y in [v_sync_start, v_sync_end). It is line-granular and changes at x==0.
  - Asserted means 1 when sync_pol=1 and 0 when sync_pol=0.
- STOPPED outputs: de=0, frame_start=0, line_start=0; hsync and vsync are at their inactive level (!sync_pol).

## Timing
- All outputs are registered.
- de, hsync, vsync, frame_start and line_start correspond to the x/y values presented in the same cycle.
- Reset values:
  - running=0, x=0, y=0, de=0, frame_start=0, line_start=0, cfg_error=0, frame_count=0.
  - hsync=0 and vsync=0 (inactive for the default sync_pol=1).
  - cfg_ready=1.
- Start latency: enable rises in cycle N -> running=1, x=0, y=0, frame_start=1 in cycle N+1.
- Stop: enable falls mid-frame -> the frame finishes. running=0 the cycle after the last pixel; x/y stay 0 from then on.
- cfg_ready falls the cycle after a valid write is accepted. It rises the cycle after the apply.
- Simultaneous events:
  - A write on the last-pixel cycle goes to the shadow slot and applies at the next frame end. It does not apply to the frame starting next cycle.
  - A write while cfg_ready=0 is not accepted.
- Reset mid-frame: all state returns to reset values immediately, including the active mode (720p defaults); the shadow slot is cleared.

## Configuration
- H14TX_TIMINGS_FRAME_COUNT_EN defined:
  - frame_count port exists.
  - It increments (wrapping at 65535 -> 0) on every last-pixel cycle in RUN/DRAIN.
  - It clears only on rst.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, enable=1 with default mode -> frame_start in cycle 1; x wraps 1649->0 with y 0->1; de is high for exactly 1280×720 cycles per 1650×750-cycle frame.
- Default mode -> hsync high for x 1390..1429 (40 cycles/line); vsync high for lines 725..729.
- Mid-frame write 8×4 mode (h: 8,4,5,7; v: 4,2,3,4; pol 0) -> cfg_ready low until the last pixel of the 720p frame; the next frame is 32 cycles; hsync is low only at x=5,6.
- Write with h_sync_start=h_active -> cfg_error pulses once; mode unchanged; cfg_ready stays 1.
- enable dropped at y=100 -> the frame completes to x=1649,y=749; running falls next cycle; frame_count=1 (macro on).
- rst asserted at x=500,y=300 with a shadow pending -> all outputs go to reset values asynchronously; the next enable runs the 720p default mode.

Source files
------------

// File: rtl/h14tx_timings_sequencer.sv
// h14tx_timings_sequencer
// Raster run/stop controller and timing-mode scheduler for the HDMI TX path.
// Owns the x/y cursor and the active mode. New modes arrive over a
// valid/ready port into a one-entry shadow slot and are applied only at a
// frame boundary, or at once while stopped. Decodes de/hsync/vsync for the
// TMDS encoder stage. All outputs are registered.
// Optional feature: define H14TX_TIMINGS_FRAME_COUNT_EN to add the 16-bit
// frame_count output.
module h14tx_timings_sequencer #(
  parameter int BitWidth  = 11,
  parameter int BitHeight = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [BitWidth-1:0]  cfg_h_total,
  input  logic [BitWidth-1:0]  cfg_h_active,
  input  logic [BitWidth-1:0]  cfg_h_sync_start,
  input  logic [BitWidth-1:0]  cfg_h_sync_end,
  input  logic [BitHeight-1:0] cfg_v_total,
  input  logic [BitHeight-1:0] cfg_v_active,
  input  logic [BitHeight-1:0] cfg_v_sync_start,
  input  logic [BitHeight-1:0] cfg_v_sync_end,
  input  logic                 cfg_sync_pol,
  output logic                 cfg_error,
  output logic                 running,
  output logic [BitWidth-1:0]  x,
  output logic [BitHeight-1:0] y,
  output logic                 de,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 frame_start,
  output logic                 line_start
`ifdef H14TX_TIMINGS_FRAME_COUNT_EN
  ,
  output logic [15:0]          frame_count
`endif
);

  typedef enum logic [1:0] {STOPPED, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [BitWidth-1:0]  h_total;
    logic [BitWidth-1:0]  h_active;
    logic [BitWidth-1:0]  h_sync_start;
    logic [BitWidth-1:0]  h_sync_end;
    logic [BitHeight-1:0] v_total;
    logic [BitHeight-1:0] v_active;
    logic [BitHeight-1:0] v_sync_start;
    logic [BitHeight-1:0] v_sync_end;
    logic                 sync_pol;
  } mode_t;

  // 1280x720 @ 60 Hz, the mode the transmitter comes up in.
  localparam mode_t DefaultMode = '{
    h_total:      BitWidth'(1650),
    h_active:     BitWidth'(1280),
    h_sync_start: BitWidth'(1390),
    h_sync_end:   BitWidth'(1430),
    v_total:      BitHeight'(750),
    v_active:     BitHeight'(720),
    v_sync_start: BitHeight'(725),
    v_sync_end:   BitHeight'(730),
    sync_pol:     1'b1
  };

  state_t               state_q, state_n;
  mode_t                mode_q, mode_n, shadow_q, cfg_mode;
  logic                 slot_empty_q;
  logic [BitWidth-1:0]  x_n;
  logic [BitHeight-1:0] y_n;
  logic                 cfg_accept, cfg_ok;
  logic                 x_last, y_last, last_pixel, apply;
  logic                 run_n, hs_on, vs_on;

  assign cfg_mode = '{cfg_h_total, cfg_h_active, cfg_h_sync_start, cfg_h_sync_end,
                      cfg_v_total, cfg_v_active, cfg_v_sync_start, cfg_v_sync_end,
                      cfg_sync_pol};

  // A write is only taken into an empty slot; malformed modes never reach it.
  assign cfg_accept = cfg_valid && slot_empty_q;
  assign cfg_ok = (cfg_h_active < cfg_h_sync_start) && (cfg_h_sync_start < cfg_h_sync_end) &&
                  (cfg_h_sync_end <= cfg_h_total) && (cfg_h_total >= BitWidth'(2)) &&
                  (cfg_v_active < cfg_v_sync_start) && (cfg_v_sync_start < cfg_v_sync_end) &&
                  (cfg_v_sync_end <= cfg_v_total) && (cfg_v_total >= BitHeight'(2));

  assign x_last     = (x == mode_q.h_total - BitWidth'(1));
  assign y_last     = (y == mode_q.v_total - BitHeight'(1));
  assign last_pixel = (state_q != STOPPED) && x_last && y_last;
  // Shadow moves to active at once when idle, otherwise on the last pixel so
  // the very next x=0,y=0 already runs the new mode.
  assign apply  = !slot_empty_q && ((state_q == STOPPED) || last_pixel);
  assign mode_n = apply ? shadow_q : mode_q;

  // Next run state and next cursor position.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n = state_q;
    x_n     = '0;
    y_n     = '0;
    unique case (state_q)
      STOPPED: if (enable) state_n = RUN;
      RUN:     if (!enable) state_n = last_pixel ? STOPPED : DRAIN;
      DRAIN: begin
        if (enable)          state_n = RUN;
        else if (last_pixel) state_n = STOPPED;
      end
      default: state_n = STOPPED;
    endcase
    if (state_q != STOPPED && state_n != STOPPED) begin
      x_n = x_last ? '0 : x + BitWidth'(1);
      y_n = x_last ? (y_last ? '0 : y + BitHeight'(1)) : y;
    end
  end

  // Decode is done on the next cursor and next mode so the registered
  // outputs line up with the x/y presented in the same cycle.
  assign run_n = (state_n != STOPPED);
  assign hs_on = (x_n >= mode_n.h_sync_start) && (x_n < mode_n.h_sync_end);
  assign vs_on = (y_n >= mode_n.v_sync_start) && (y_n < mode_n.v_sync_end);

  // Run state, cursor and decoded raster outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= STOPPED;
      running     <= 1'b0;
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      state_q     <= state_n;
      running     <= run_n;
      x           <= x_n;
      y           <= y_n;
      de          <= run_n && (x_n < mode_n.h_active) && (y_n < mode_n.v_active);
      hsync       <= (run_n && hs_on) ? mode_n.sync_pol : ~mode_n.sync_pol;
      vsync       <= (run_n && vs_on) ? mode_n.sync_pol : ~mode_n.sync_pol;
      frame_start <= run_n && (x_n == '0) && (y_n == '0);
      line_start  <= run_n && (x_n == '0);
    end
  end

  // Active mode, shadow-slot occupancy and the invalid-write pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q       <= DefaultMode;
      slot_empty_q <= 1'b1;
      cfg_error    <= 1'b0;
    end else begin
      cfg_error <= cfg_accept && !cfg_ok;
      if (apply) begin
        mode_q       <= shadow_q;
        slot_empty_q <= 1'b1;
      end
      if (cfg_accept && cfg_ok) slot_empty_q <= 1'b0;
    end
  end

  // Shadow mode data.
  // NOTE: no reset on this storage; slot_empty_q guarantees it is never read before being written.
  always_ff @(posedge clk) begin
    if (cfg_accept && cfg_ok) shadow_q <= cfg_mode;
  end

  assign cfg_ready = slot_empty_q;

`ifdef H14TX_TIMINGS_FRAME_COUNT_EN
  // Completed-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_count <= '0;
    else if (last_pixel) frame_count <= frame_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_h14tx_timings_sequencer.sv
// Bench for h14tx_timings_sequencer: directed stimulus with a frame scoreboard.
// Stimulus pushes the expected per-frame statistics; a monitor closes each
// frame at the next frame_start (or when running falls) and compares.
module tb_h14tx_timings_sequencer;

  logic        clk = 1'b0;
  logic        rst, enable, cfg_valid, cfg_ready, cfg_sync_pol, cfg_error;
  logic [10:0] cfg_h_total, cfg_h_active, cfg_h_sync_start, cfg_h_sync_end;
  logic [9:0]  cfg_v_total, cfg_v_active, cfg_v_sync_start, cfg_v_sync_end;
  logic        running, de, hsync, vsync, frame_start, line_start;
  logic [10:0] x;
  logic [9:0]  y;
`ifdef H14TX_TIMINGS_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  h14tx_timings_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_h_total(cfg_h_total), .cfg_h_active(cfg_h_active),
    .cfg_h_sync_start(cfg_h_sync_start), .cfg_h_sync_end(cfg_h_sync_end),
    .cfg_v_total(cfg_v_total), .cfg_v_active(cfg_v_active),
    .cfg_v_sync_start(cfg_v_sync_start), .cfg_v_sync_end(cfg_v_sync_end),
    .cfg_sync_pol(cfg_sync_pol), .cfg_error(cfg_error),
    .running(running), .x(x), .y(y), .de(de), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start), .line_start(line_start)
`ifdef H14TX_TIMINGS_FRAME_COUNT_EN
    , .frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int cycles;
    int de_cnt;
    int hs_cnt;   // cycles with hsync asserted (polarity-aware)
    int vs_cnt;   // cycles with vsync asserted (polarity-aware)
    bit pol;
  } frame_t;

  frame_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_frame(input int cyc, input int de_n, input int hs_n, input int vs_n, input bit pol);
    frame_t f;
    f.cycles = cyc; f.de_cnt = de_n; f.hs_cnt = hs_n; f.vs_cnt = vs_n; f.pol = pol;
    exp_q.push_back(f);
  endtask

  task automatic set_cfg(input int ht, input int ha, input int hs, input int he,
                         input int vt, input int va, input int vs, input int ve, input bit pol);
    cfg_h_total = 11'(ht); cfg_h_active = 11'(ha); cfg_h_sync_start = 11'(hs); cfg_h_sync_end = 11'(he);
    cfg_v_total = 10'(vt); cfg_v_active = 10'(va); cfg_v_sync_start = 10'(vs); cfg_v_sync_end = 10'(ve);
    cfg_sync_pol = pol;
  endtask

  // Advance to the negedge where the cursor sits at (wx, wy), bounded.
  task automatic wait_xy(input int wx, input int wy, input string name);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (x == 11'(wx) && y == 10'(wy)) return;
    end
    check({"timeout_", name}, 0, 1);
  endtask

  // Assert rst between edges and confirm outputs clear before any clock edge.
  task automatic async_reset(input string name);
    @(negedge clk);
    #2 rst = 1'b1;
    enable = 1'b0;
    cfg_valid = 1'b0;
    #1;
    check({name, "_flags"}, {running, de, hsync, vsync, frame_start, line_start, cfg_ready, cfg_error},
          8'b0000_0010);
    check({name, "_x"}, x, 0);
    check({name, "_y"}, y, 0);
`ifdef H14TX_TIMINGS_FRAME_COUNT_EN
    check({name, "_frame_count"}, frame_count, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Frame monitor.
  bit m_open = 0;
  int m_cyc, m_de, m_hs_hi, m_vs_hi;
  frame_t m_exp;

  always @(negedge clk) begin
    if (rst) begin
      m_open = 0;
    end else begin
      if (m_open && (!running || frame_start)) begin
        m_open = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", m_cyc, 0);
        end else begin
          m_exp = exp_q.pop_front();
          check("frame_cycles", m_cyc, m_exp.cycles);
          check("frame_de", m_de, m_exp.de_cnt);
          check("frame_hsync", m_hs_hi, m_exp.pol ? m_exp.hs_cnt : m_exp.cycles - m_exp.hs_cnt);
          check("frame_vsync", m_vs_hi, m_exp.pol ? m_exp.vs_cnt : m_exp.cycles - m_exp.vs_cnt);
        end
      end
      if (running && frame_start) begin
        m_open = 1; m_cyc = 0; m_de = 0; m_hs_hi = 0; m_vs_hi = 0;
      end
      if (m_open) begin
        m_cyc++;
        m_de    += int'(de);
        m_hs_hi += int'(hsync);
        m_vs_hi += int'(vsync);
      end
    end
  end

  int err_seen = 0;
  always @(negedge clk) if (!rst && cfg_error) err_seen++;

  int hs_cnt, de_cnt, vs_cnt, bad_xy, bad_hs, ready_hi;
  logic [7:0] hs_line;

  initial begin
    rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_flags", {running, de, hsync, vsync, frame_start, line_start, cfg_ready, cfg_error},
          8'b0000_0010);
    check("rst_xy", {x, y}, 0);
`ifdef H14TX_TIMINGS_FRAME_COUNT_EN
    check("rst_frame_count", frame_count, 0);
`endif

    // 720p default: start latency, first two lines, mid-frame write held off.
    enable = 1'b1;
    hs_cnt = 0; de_cnt = 0; vs_cnt = 0; bad_xy = 0; bad_hs = 0; ready_hi = 0;
    for (int k = 0; k < 3300; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("start_running", running, 1);
        check("start_frame_start", frame_start, 1);
      end
      if (x !== 11'(k % 1650) || y !== 10'(k / 1650)) bad_xy++;
      if (k < 1650) begin
        hs_cnt += int'(hsync);
        de_cnt += int'(de);
        if (hsync && (k < 1390 || k >= 1430)) bad_hs++;
      end
      vs_cnt += int'(vsync);
      if (k == 1649) check("wrap_last_x", x, 1649);
      if (k == 1650) begin
        check("wrap_x0", x, 0);
        check("wrap_y1", y, 1);
        check("wrap_line_start", {line_start, frame_start}, 2'b10);
      end
      if (k == 200) begin
        check("ready_before_write", cfg_ready, 1);
        set_cfg(8, 4, 5, 7, 4, 2, 3, 4, 1'b0);
        cfg_valid = 1'b1;
      end
      if (k == 201) begin
        cfg_valid = 1'b0;
        check("ready_after_write", cfg_ready, 0);
      end
      if (k > 201) ready_hi += int'(cfg_ready);
    end
    check("p720_cursor", bad_xy, 0);
    check("p720_hsync_line0", hs_cnt, 40);
    check("p720_hsync_pos", bad_hs, 0);
    check("p720_de_line0", de_cnt, 1280);
    check("p720_vsync_top", vs_cnt, 0);
    check("p720_ready_held", ready_hi, 0);

    // Reset with the 8x4 mode pending: shadow must be dropped.
    async_reset("rst_pending");
    @(negedge clk);
    enable = 1'b1;
    hs_cnt = 0;
    for (int k = 0; k < 2150; k++) begin
      @(negedge clk);
      if (k == 0) check("restart_frame_start", frame_start, 1);
      if (k < 1650) hs_cnt += int'(hsync);
      if (k == 1649) check("restart_720p_x", x, 1649);
    end
    check("restart_hsync_line0", hs_cnt, 40);
    async_reset("rst_mid_frame");

    // Stopped write of 8x4, pol 0: applies one cycle later.
    @(negedge clk);
    set_cfg(8, 4, 5, 7, 4, 2, 3, 4, 1'b0);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("stopped_ready_low", cfg_ready, 0);
    @(negedge clk);
    check("stopped_ready_high", cfg_ready, 1);
    check("stopped_sync_inactive", {hsync, vsync}, 2'b11);
    push_frame(32, 8, 8, 8, 1'b0);
    push_frame(32, 8, 8, 8, 1'b0);
    push_frame(32, 8, 8, 8, 1'b0);
    enable = 1'b1;
    wait_xy(0, 0, "f1_start");
    check("f1_frame_start", {running, frame_start}, 2'b11);
    hs_line = '0;
    hs_line[x[2:0]] = hsync;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      hs_line[x[2:0]] = hsync;
    end
    check("m8x4_hsync_pattern", hs_line, 8'b1001_1111);

    // Invalid write in F2: h_sync_start == h_active.
    wait_xy(0, 0, "f2_start");
    wait_xy(2, 1, "f2_mid");
    check("inv_ready_before", cfg_ready, 1);
    set_cfg(8, 4, 4, 7, 4, 2, 3, 4, 1'b0);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("inv_error_pulse", {cfg_error, cfg_ready}, 2'b11);
    @(negedge clk);
    check("inv_error_clear", {cfg_error, cfg_ready}, 2'b01);
    check("inv_error_count", err_seen, 1);

    // Mid-frame write of 10x5, pol 1, during F3.
    wait_xy(0, 0, "f3_start");
    wait_xy(3, 1, "f3_mid");
    set_cfg(10, 6, 7, 9, 5, 3, 4, 5, 1'b1);
    cfg_valid = 1'b1;
    push_frame(50, 18, 10, 10, 1'b1);
    push_frame(50, 18, 10, 10, 1'b1);
    push_frame(50, 18, 10, 10, 1'b1);
    @(negedge clk);
    cfg_valid = 1'b0;
    check("mid_ready_low", cfg_ready, 0);
    wait_xy(7, 3, "f3_last");
    check("mid_ready_low_last", cfg_ready, 0);
    @(negedge clk);
    check("mid_apply", {cfg_ready, frame_start, hsync, vsync}, 4'b1100);

    // Write on the last-pixel cycle of F5: F6 stays 10x5, F7 onward 6x3.
    wait_xy(9, 4, "f4_last");
    wait_xy(9, 4, "f5_last");
    check("lp_ready_before", cfg_ready, 1);
    set_cfg(6, 3, 4, 5, 3, 1, 2, 3, 1'b1);
    cfg_valid = 1'b1;
    push_frame(18, 3, 3, 6, 1'b1);
    push_frame(18, 3, 3, 6, 1'b1);
    @(negedge clk);
    cfg_valid = 1'b0;
    check("lp_next_frame", {frame_start, cfg_ready}, 2'b10);
    wait_xy(9, 4, "f6_last");
    check("lp_ready_low_last", cfg_ready, 0);
    @(negedge clk);
    check("lp_apply", {cfg_ready, frame_start}, 2'b11);

    // F7: brief enable drop, DRAIN returns to RUN.
    wait_xy(2, 1, "f7_mid");
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    enable = 1'b1;
    wait_xy(0, 0, "f8_start");
    check("drain_resume", {running, frame_start}, 2'b11);

    // F8: drop enable for good; frame completes then stops.
    wait_xy(2, 1, "f8_mid");
    enable = 1'b0;
    wait_xy(5, 2, "f8_last");
    check("stop_last_running", running, 1);
    @(negedge clk);
    check("stop_flags", {running, de, frame_start, line_start, hsync, vsync}, 6'b0);
    check("stop_xy", {x, y}, 0);
    repeat (3) @(negedge clk);
    check("stop_held", {running, x, y}, 0);
`ifdef H14TX_TIMINGS_FRAME_COUNT_EN
    check("frame_count", frame_count, 8);
`endif
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
